crc_checker: RTL
================

// Module: crc_checker
// PURPOSE
//  Serial CRC-8 receiver/checker; far end of the link fed by the serial CRC-8 generator.
//  Recomputes CRC over payload bits (ACTIVE), then compares 8 trailing CRC bits (CRC_VLD), LSB first.
//  Reports one-cycle DONE with CRC_OK / FRAME_ERR; sits after the bit deserialiser in the RX path.
// PARAMETERS
//  SEED   8'hD8  LFSR init value; must match transmitter seed
// PORTS
//  CLK        in   1  clock, all logic on rising edge
//  RST        in   1  asynchronous, active-low reset
//  DATA       in   1  serial bit (payload or CRC), sampled when ACTIVE or CRC_VLD high
//  ACTIVE     in   1  DATA is a payload bit this cycle
//  CRC_VLD    in   1  DATA is a CRC bit this cycle (LSB of CRC first)
//  DONE       out  1  one-cycle pulse: frame check complete
//  CRC_OK     out  1  1 = all 8 CRC bits matched; valid with DONE, held until next DONE
//  FRAME_ERR  out  1  1 = protocol violation ended frame; valid with DONE, held until next DONE
//  SYNDROME   out  8  received ^ expected CRC (only with CRC_CHK_SYNDROME_EN)
// BEHAVIOUR
//  Reset: LFSR=SEED, state=IDLE, bit count=0, mismatch=0, DONE=0, CRC_OK=0, FRAME_ERR=0, SYNDROME=0.
//  LFSR update per payload bit: fb=LFSR[0]^DATA;
//   LFSR <= {fb, LFSR[7]^fb, LFSR[6], LFSR[5], LFSR[4], LFSR[3]^fb, LFSR[2], LFSR[1]}.
//  CRC bit check: expected bit = LFSR[0]; mismatch |= DATA^LFSR[0]; LFSR >>= 1 (MSB fill 0);
//   bit count++.
//  States:
//   IDLE : ACTIVE -> PAYLOAD (bit absorbed); CRC_VLD -> CHECK (empty frame, bit checked vs SEED).
//   PAYLOAD: ACTIVE -> absorb; CRC_VLD -> CHECK, first CRC bit checked same cycle.
//   CHECK: CRC_VLD -> check; on 8th bit -> IDLE.
//   Both low in any state: stall, all state held (gaps allowed).
//  Completion: on edge sampling 8th CRC bit: DONE=1 next cycle for one cycle,
//   CRC_OK=~(mismatch|this bit mismatch), FRAME_ERR=0; LFSR reloaded to SEED, count=0, mismatch=0.
//  Latency: DONE 1 cycle after last CRC bit; next frame's first bit may arrive in the DONE cycle.
//  Errors (DONE pulse, CRC_OK=0, FRAME_ERR=1, LFSR->SEED, state->IDLE, offending bit discarded):
//   - ACTIVE and CRC_VLD high same cycle, any state.
//   - ACTIVE high in CHECK (CRC field truncated, count 1..7).
//  Count is 3-bit wrapping 7->0 exactly at completion; never exceeds 8 CRC bits per frame.
//  Reset mid-frame: immediate return to reset values; no DONE emitted for aborted frame.
// CONFIGURATION
//  CRC_CHK_SYNDROME_EN defined: SYNDROME port present; 8-bit shift register collects
//   DATA^LFSR[0] per CRC bit (bit i = CRC bit i); loaded to SYNDROME with DONE,
//   held until next DONE; 8'h00 on FRAME_ERR.
//  Not defined: SYNDROME port and collector absent; CRC_OK from 1-bit sticky mismatch only.
// TESTING
//  1 Empty frame, SEED=D8: CRC_VLD bits 0,0,0,1,1,0,1,1 -> DONE 1 cycle later, CRC_OK=1, FRAME_ERR=0.
//  2 Payload 8'h00 (8 ACTIVE bits), then CRC 8'h14 LSB-first (0,0,1,0,1,0,0,0)
//     -> CRC_OK=1; same frame with CRC 8'h15 -> CRC_OK=0, SYNDROME=8'h01 (if enabled).
//  3 Test 2 good frame with 3-cycle idle gaps inside payload and CRC field -> identical result, DONE once.
//  4 Back-to-back: second frame's first ACTIVE bit in DONE cycle of first -> both frames CRC_OK=1.
//  5 ACTIVE reasserted after 4 CRC bits -> DONE, CRC_OK=0, FRAME_ERR=1; ACTIVE & CRC_VLD together
//     -> same; next good frame (test 2) -> CRC_OK=1.
//  6 RST low after 5 payload bits, release, send test 2 frame -> no DONE during reset,
//     then CRC_OK=1; all outputs 0 while RST low.

Source files
------------

// File: rtl/crc_checker.sv
// crc_checker -- serial CRC-8 receiver/checker.
// Recomputes the CRC over the payload bits, then compares the 8 trailing
// CRC bits (LSB first) against the recomputed value. Reports each frame
// with a one-cycle DONE pulse and held CRC_OK / FRAME_ERR flags.
// Optional feature: define CRC_CHK_SYNDROME_EN to add the SYNDROME port
// (received CRC xor expected CRC, bit i = CRC bit i).
module crc_checker #(
    parameter logic [7:0] SEED = 8'hD8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DATA,
    input  logic       ACTIVE,
    input  logic       CRC_VLD,
    output logic       DONE,
    output logic       CRC_OK,
    output logic       FRAME_ERR
`ifdef CRC_CHK_SYNDROME_EN
    ,
    output logic [7:0] SYNDROME
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] lfsr, lfsr_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       mismatch, mismatch_nxt;
    logic       done_nxt, crc_ok_nxt, frame_err_nxt;

    logic       fb;
    logic       bit_err;
    logic [7:0] lfsr_absorb;
    logic       proto_err;

`ifdef CRC_CHK_SYNDROME_EN
    logic [7:0] syn_sr, syn_sr_nxt;
    logic [7:0] syndrome_nxt;
`endif

    // Per-bit helpers: LFSR step for a payload bit and mismatch of a CRC bit.
    always_comb begin
        fb          = lfsr[0] ^ DATA;
        lfsr_absorb = {fb, lfsr[7] ^ fb, lfsr[6], lfsr[5], lfsr[4],
                       lfsr[3] ^ fb, lfsr[2], lfsr[1]};
        bit_err     = DATA ^ lfsr[0];
        // Both strobes together, or payload arriving inside the CRC field,
        // ends the frame as a protocol violation.
        proto_err   = ACTIVE && (CRC_VLD || (state == CHECK));
    end

    // Next-state and next-datapath decode for one serial bit.
    always_comb begin
        // NOTE: every signal gets a default before any branch so that no
        // path leaves it unassigned, which would infer a latch.
        state_nxt     = state;
        lfsr_nxt      = lfsr;
        cnt_nxt       = cnt;
        mismatch_nxt  = mismatch;
        done_nxt      = 1'b0;
        crc_ok_nxt    = CRC_OK;
        frame_err_nxt = FRAME_ERR;
`ifdef CRC_CHK_SYNDROME_EN
        syn_sr_nxt    = syn_sr;
        syndrome_nxt  = SYNDROME;
`endif

        if (proto_err) begin
            // Offending bit is discarded; frame closed with an error report.
            state_nxt     = IDLE;
            lfsr_nxt      = SEED;
            cnt_nxt       = 3'd0;
            mismatch_nxt  = 1'b0;
            done_nxt      = 1'b1;
            crc_ok_nxt    = 1'b0;
            frame_err_nxt = 1'b1;
`ifdef CRC_CHK_SYNDROME_EN
            syn_sr_nxt    = 8'h00;
            syndrome_nxt  = 8'h00;
`endif
        end else if (ACTIVE) begin
            // Payload bit (only reachable from IDLE or PAYLOAD here).
            state_nxt = PAYLOAD;
            lfsr_nxt  = lfsr_absorb;
        end else if (CRC_VLD) begin
            // CRC bit: compare against LFSR LSB, then expose the next bit.
            lfsr_nxt     = {1'b0, lfsr[7:1]};
            mismatch_nxt = mismatch | bit_err;
            cnt_nxt      = cnt + 3'd1;
            state_nxt    = CHECK;
`ifdef CRC_CHK_SYNDROME_EN
            syn_sr_nxt   = {bit_err, syn_sr[7:1]};
`endif
            if (cnt == 3'd7) begin
                state_nxt     = IDLE;
                lfsr_nxt      = SEED;
                cnt_nxt       = 3'd0;
                mismatch_nxt  = 1'b0;
                done_nxt      = 1'b1;
                crc_ok_nxt    = ~(mismatch | bit_err);
                frame_err_nxt = 1'b0;
`ifdef CRC_CHK_SYNDROME_EN
                syn_sr_nxt    = 8'h00;
                syndrome_nxt  = {bit_err, syn_sr[7:1]};
`endif
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and output registers; reset aborts any frame silently.
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this clock edge.
        if (!RST) begin
            lfsr      <= SEED;
            cnt       <= 3'd0;
            mismatch  <= 1'b0;
            DONE      <= 1'b0;
            CRC_OK    <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            lfsr      <= lfsr_nxt;
            cnt       <= cnt_nxt;
            mismatch  <= mismatch_nxt;
            DONE      <= done_nxt;
            CRC_OK    <= crc_ok_nxt;
            FRAME_ERR <= frame_err_nxt;
        end
    end

`ifdef CRC_CHK_SYNDROME_EN
    // Syndrome collector and its held output copy.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            syn_sr   <= 8'h00;
            SYNDROME <= 8'h00;
        end else begin
            syn_sr   <= syn_sr_nxt;
            SYNDROME <= syndrome_nxt;
        end
    end
`endif

endmodule
